vc_test_sink_chk: RTL
=====================

Name: vc_test_sink_chk

Overview:
- Parametrised successor to the single-channel file-loaded test sink.
- Holds an expected-message table and checks received val/rdy messages in order, with a per-entry don't-care mask.
- Inserts pseudo-random backpressure by stalling rdy for 0..p_max_delay cycles.
- Counts mismatches, detects stalls with a timeout, and exposes done/failed as ports so the pass/fail verdict is observable in hardware.
- Sits at the response end of processor and memory test harnesses.

Parameters:
- p_msg_nbits, 32, message width in bits.
- p_num_msgs, 1024, expected-table depth (power of two, at least 2).
- p_max_delay, 0, maximum random stall cycles inserted before each acceptance; 0 means never stall.
- p_lfsr_seed, 16'hACE1, reset seed of the 16-bit delay LFSR (must be nonzero).
- p_timeout, 0, cycles with val low and not done before timeout fires; 0 disables the timeout.
- p_sim_mode, 0, when 1, print diagnostics and $finish on the first mismatch or timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  write the expected table this cycle.
- load_addr  in  $clog2(p_num_msgs)  table write address.
- load_data  in  p_msg_nbits  expected message.
- load_mask  in  p_msg_nbits  care mask; a 1 bit is compared.
- num_msgs  in  $clog2(p_num_msgs)+1  number of valid table entries; sampled every cycle.
- val  in  1  message valid.
- rdy  out  1  sink ready.
- msg  in  p_msg_nbits  received message.
- done  out  1  all num_msgs messages received.
- failed  out  1  sticky: mismatch or timeout occurred.
- num_errors  out  16  saturating mismatch count.
- index  out  $clog2(p_num_msgs)+1  number of messages accepted so far.

Behaviour:
- Reset values: rdy=0, done=0, failed=0, num_errors=0, index=0, LFSR=p_lfsr_seed, delay counter=0, timeout counter=0, state=RST.
- reset_reg is a registered copy of reset. rdy and done are forced to 0 while reset_reg=1, i.e. for one extra cycle after reset deasserts.
- The table is written only by load_en, in any state. Table contents are not cleared by reset. A write to the entry being compared in the same cycle takes effect on the next cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle that reset is not asserted.
- FSM states:
  - RST: entered on reset; lasts one cycle after deassert; then goes to DLY if a stall is needed, else RDY.
  - DLY: delay counter is loaded with LFSR mod (p_max_delay+1). rdy=0. The counter decrements each cycle. When it reaches 0, go to RDY; a loaded value of 0 passes straight through to RDY with no stall cycle.
  - RDY: rdy=1. On val&&rdy, check the message and increment index. Next state is DONE if index+1==num_msgs, else DLY (or RDY when p_max_delay=0).
  - DONE: rdy=0, done=1. If num_msgs is later raised above index, return to DLY.
- num_msgs=0: go straight from RST to DONE.
- Check rule: pass iff ((msg ^ exp) & mask) == 0. On a failure, num_errors increments (saturating at 16'hFFFF) and failed is set; both become visible the cycle after the transfer.
- Accept latency: val is sampled in the same cycle rdy=1; zero-cycle accept.
- Timeout: the counter increments each cycle in which val=0, state is not DONE and not RST, and p_timeout>0. It clears on any transfer. Reaching p_timeout sets failed. The counter then holds, and any later transfer clears it.
- val asserted while rdy=0: ignored, not counted; the sender must hold the message.
- Reset mid-operation: all state returns to its reset value on the next edge. Any in-flight message is dropped. The table is retained.
- Assertions when not in reset: val and msg (when val=1) must not be X. p_sim_mode=1 prints module path, index, expected, actual and mask, then calls $finish.
- A final block reports each entry from index to num_msgs-1 as "[ FAILED ] expected = %x, actual = None".

Optional Feature:
- Macro: VC_TEST_SINK_CHK_FIRST_ERR_EN.
- When defined, add these output ports:
  - first_err_val (1)
  - first_err_index ($clog2(p_num_msgs)+1)
  - first_err_actual (p_msg_nbits)
- On the first mismatch after reset, these capture the index and msg and set first_err_val=1. They hold until reset. Later errors do not overwrite them, and a timeout does not set them. Reset value is all zeros.
- When undefined, the ports and registers are absent; all other behaviour is identical.

Test Plan:
- Load 4 entries {01,02,03,04}, all-ones masks, num_msgs=4, p_max_delay=0; send them back to back -> rdy high from cycle 2 after reset, four accepts in 4 cycles, done=1, failed=0, num_errors=0, index=4.
- Same table; send 01,FF,03,EE -> num_errors=2, failed=1, done=1; with FIRST_ERR_EN: first_err_index=1, first_err_actual=FF.
- Load exp=12345678, mask=FFFF0000; send 1234ABCD -> pass; then send 1235ABCD -> fail, num_errors=1.
- p_max_delay=3, 50 messages, val held high -> every message accepted, no message spends more than 4 cycles with rdy=0, error-free, done=1; a second run with the same seed shows an identical rdy pattern.
- p_timeout=10, num_msgs=2; send 1 message, then val=0 for 10 cycles -> failed=1 on the 10th idle cycle, done=0, index=1.
- Assert reset after 2 of 4 messages -> index=0, num_errors=0, rdy=0 for 2 cycles; resend all 4 -> done=1 with the table intact.

Source files
------------

// File: rtl/vc_test_sink_chk.sv
// rtl/vc_test_sink_chk.sv - checking val/rdy test sink with expected table, masks, random stalls and timeout
// Optional first-error capture ports are enabled by defining VC_TEST_SINK_CHK_FIRST_ERR_EN.
module vc_test_sink_chk #(
  parameter int          p_msg_nbits = 32,
  parameter int          p_num_msgs  = 1024,
  parameter int          p_max_delay = 0,
  parameter logic [15:0] p_lfsr_seed = 16'hACE1,
  parameter int          p_timeout   = 0,
  parameter int          p_sim_mode  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load_en,
  input  logic [$clog2(p_num_msgs)-1:0] load_addr,
  input  logic [p_msg_nbits-1:0]        load_data,
  input  logic [p_msg_nbits-1:0]        load_mask,
  input  logic [$clog2(p_num_msgs):0]   num_msgs,
  input  logic                          val,
  output logic                          rdy,
  input  logic [p_msg_nbits-1:0]        msg,
  output logic                          done,
  output logic                          failed,
  output logic [15:0]                   num_errors,
  output logic [$clog2(p_num_msgs):0]   index
`ifdef VC_TEST_SINK_CHK_FIRST_ERR_EN
  ,
  output logic                          first_err_val,
  output logic [$clog2(p_num_msgs):0]   first_err_index,
  output logic [p_msg_nbits-1:0]        first_err_actual
`endif
);

  localparam int AW = $clog2(p_num_msgs);
  localparam int IW = AW + 1;

  localparam logic [1:0] ST_RST  = 2'd0;
  localparam logic [1:0] ST_DLY  = 2'd1;
  localparam logic [1:0] ST_RDY  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [15:0] DMOD   = 16'(p_max_delay + 1);
  localparam logic [31:0] TO_LIM = 32'(p_timeout);

  logic [p_msg_nbits-1:0] exp_mem  [p_num_msgs];
  logic [p_msg_nbits-1:0] mask_mem [p_num_msgs];

  logic        reset_reg;
  logic [15:0] lfsr;
  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [1:0]  resume_state;
  logic [15:0] dly_cnt;
  logic [15:0] dly_pick;
  logic [31:0] to_cnt;
  logic        to_run;
  logic        timeout_hit;
  logic        xfer;
  logic        mismatch;
  logic [IW-1:0] idx_next;
  logic [p_msg_nbits-1:0] exp_cur;
  logic [p_msg_nbits-1:0] mask_cur;

  // Table has no reset so it survives a mid-run reset of the checker.
  always_ff @(posedge clk) begin
    if (load_en) begin
      exp_mem[load_addr]  <= load_data;
      mask_mem[load_addr] <= load_mask;
    end
  end

  always_ff @(posedge clk) begin
    reset_reg <= reset;
  end

  always_ff @(posedge clk) begin
    if (reset)
      lfsr <= p_lfsr_seed;
    else
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign dly_pick     = lfsr % DMOD;
  assign resume_state = (dly_pick != 16'd0) ? ST_DLY : ST_RDY;

  assign rdy  = (state == ST_RDY) && !reset_reg;
  assign done = (state == ST_DONE) && !reset_reg;
  assign xfer = val && rdy;

  assign exp_cur  = exp_mem[index[AW-1:0]];
  assign mask_cur = mask_mem[index[AW-1:0]];
  assign mismatch = |((msg ^ exp_cur) & mask_cur);
  assign idx_next = index + 1'b1;

  assign to_run = (p_timeout > 0) && !val && (state != ST_DONE) && (state != ST_RST)
                  && (to_cnt != TO_LIM);
  assign timeout_hit = to_run && ((to_cnt + 32'd1) == TO_LIM);

  always_comb begin
    state_next = state;
    case (state)
      ST_RST: begin
        if (!reset_reg)
          state_next = (index >= num_msgs) ? ST_DONE : resume_state;
      end
      ST_DLY: begin
        if (dly_cnt <= 16'd1)
          state_next = ST_RDY;
      end
      ST_RDY: begin
        if (xfer)
          state_next = (idx_next >= num_msgs) ? ST_DONE : resume_state;
        else if (index >= num_msgs)
          state_next = ST_DONE;
      end
      default: begin
        if (num_msgs > index)
          state_next = resume_state;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RST;
      dly_cnt    <= 16'd0;
      index      <= '0;
      num_errors <= 16'd0;
      failed     <= 1'b0;
      to_cnt     <= 32'd0;
    end else begin
      state <= state_next;
      // Load on entry to DLY; a zero pick never enters DLY at all.
      if ((state_next == ST_DLY) && (state != ST_DLY))
        dly_cnt <= dly_pick;
      else if (state == ST_DLY)
        dly_cnt <= dly_cnt - 16'd1;

      if (xfer) begin
        index <= idx_next;
        if (mismatch) begin
          failed <= 1'b1;
          if (num_errors != 16'hFFFF)
            num_errors <= num_errors + 16'd1;
        end
      end

      if (timeout_hit)
        failed <= 1'b1;

      if (xfer)
        to_cnt <= 32'd0;
      else if (to_run)
        to_cnt <= to_cnt + 32'd1;
    end
  end

`ifdef VC_TEST_SINK_CHK_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      first_err_val    <= 1'b0;
      first_err_index  <= '0;
      first_err_actual <= '0;
    end else if (xfer && mismatch && !first_err_val) begin
      first_err_val    <= 1'b1;
      first_err_index  <= index;
      first_err_actual <= msg;
    end
  end
`endif

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset === 1'b0) begin
      assert (!$isunknown(val)) else $error("%m: val is X");
      if (val === 1'b1)
        assert (!$isunknown(msg)) else $error("%m: msg is X while val=1");
      if (p_sim_mode != 0) begin
        if (xfer && mismatch) begin
          $display("%m: mismatch index=%0d expected=%x actual=%x mask=%x",
                   index, exp_cur, msg, mask_cur);
          $finish;
        end
        if (timeout_hit) begin
          $display("%m: timeout at index=%0d", index);
          $finish;
        end
      end
    end
  end

  final begin
    for (int i = int'(index); i < int'(num_msgs) && i < p_num_msgs; i++)
      $display("[ FAILED ] expected = %x, actual = None", exp_mem[AW'(i)]);
  end
`endif

endmodule
